// File: rtl/cordic_quadrant.sv
// cordic_quadrant: full-circle wrapper around the first-quadrant iterative CORDIC core.
// Splits the angle into quadrant/offset, sequences the core and applies the sign/swap fix-up.
module cordic_quadrant #(
  parameter int BIT_WIDTH = 16,
  parameter int TIMEOUT   = 40
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH+1:0]   in_angle,
  output logic                   core_start,
  output logic [BIT_WIDTH-1:0]   core_target,
  input  logic                   core_done,
  input  logic [BIT_WIDTH-1:0]   core_x,
  input  logic [BIT_WIDTH-1:0]   core_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH:0]     out_cos,
  output logic [BIT_WIDTH:0]     out_sin,
  output logic                   out_err
);

  localparam int OW = BIT_WIDTH + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Rotates first-quadrant magnitudes into the quadrant of the original angle; returns {cos, sin}.
  function automatic logic [2*OW-1:0] fixup(
    input logic [1:0]           q,
    input logic [BIT_WIDTH-1:0] x,
    input logic [BIT_WIDTH-1:0] y
  );
    logic [OW-1:0]   cx;
    logic [OW-1:0]   sy;
    logic [OW-1:0]   ncx;
    logic [OW-1:0]   nsy;
    logic [2*OW-1:0] r;
    cx  = {1'b0, x};
    sy  = {1'b0, y};
    ncx = OW'(0) - cx;
    nsy = OW'(0) - sy;
    case (q)
      2'd0:    r = {cx, sy};
      2'd1:    r = {nsy, cx};
      2'd2:    r = {ncx, nsy};
      2'd3:    r = {sy, ncx};
      default: r = {cx, sy};
    endcase
    return r;
  endfunction

  state_t                 state_r;
  state_t                 state_s;
  logic [CW-1:0]          cnt_r;
  logic [1:0]             quad_r;
  logic [BIT_WIDTH-1:0]   target_r;
  logic                   core_start_r;
  logic                   out_valid_r;
  logic [OW-1:0]          out_cos_r;
  logic [OW-1:0]          out_sin_r;
  logic                   out_err_r;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   take_done_s;
  logic                   take_timeout_s;
  logic [2*OW-1:0]        fix_s;

  // Handshake qualification and next-state selection.
  always_comb begin
    state_s        = state_r;
    take_done_s    = 1'b0;
    take_timeout_s = 1'b0;
    in_ready_s     = reset_n & ((state_r == ST_IDLE) | ((state_r == ST_OUT) & out_ready));
    accept_s       = in_valid & in_ready_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A done pulse in the final counted cycle still wins over the timeout.
        if (core_done) begin
          take_done_s = 1'b1;
          state_s     = ST_OUT;
        end else if (cnt_r == CNT_LAST) begin
          take_timeout_s = 1'b1;
          state_s        = ST_OUT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (accept_s) begin
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Fix-up of the magnitudes presented by the core this cycle.
  always_comb begin
    fix_s = fixup(quad_r, core_x, core_y);
  end

  // State, captured angle, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      quad_r       <= 2'd0;
      target_r     <= '0;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_cos_r    <= '0;
      out_sin_r    <= '0;
      out_err_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      core_start_r <= (state_s == ST_START);
      out_valid_r  <= (state_s == ST_OUT);
      if (accept_s) begin
        quad_r   <= in_angle[BIT_WIDTH+1:BIT_WIDTH];
        target_r <= in_angle[BIT_WIDTH-1:0];
      end
      if ((state_s == ST_WAIT) && (state_r != ST_WAIT)) begin
        cnt_r <= '0;
      end else if ((state_r == ST_WAIT) && !core_done) begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (take_done_s) begin
        out_cos_r <= fix_s[2*OW-1:OW];
        out_sin_r <= fix_s[OW-1:0];
        out_err_r <= 1'b0;
      end else if (take_timeout_s) begin
        out_cos_r <= '0;
        out_sin_r <= '0;
        out_err_r <= 1'b1;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign core_start  = core_start_r;
  assign core_target = target_r;
  assign out_valid   = out_valid_r;
  assign out_cos     = out_cos_r;
  assign out_sin     = out_sin_r;
  assign out_err     = out_err_r;

endmodule
